// File: rtl/fb_arbiter_if.sv
// Framebuffer arbiter bus: display read port, CPU port, clear control and RAM port.
// Latency: none (wires only).
// Backpressure: none; the CPU side holds cpuReq until cpuAck, display is never stalled.
interface fb_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  // resolution mode, sampled only when a clear starts
  logic              hires;

  // display scanout read port
  logic              dispReq;
  logic [ADDR_W-1:0] dispAddr;
  logic [DATA_W-1:0] dispData;
  logic              dispValid;

  // CPU request/ack port
  logic              cpuReq;
  logic              cpuWe;
  logic [ADDR_W-1:0] cpuAddr;
  logic [DATA_W-1:0] cpuWData;
  logic [DATA_W-1:0] cpuRData;
  logic              cpuAck;

  // clear sequencer control
  logic              clearStart;
  logic              clearBusy;

  // single-port framebuffer RAM
  logic [ADDR_W-1:0] ramAddr;
  logic              ramWe;
  logic [DATA_W-1:0] ramWData;
  logic [DATA_W-1:0] ramRData;

  // arbiter side
  modport slave (
    input  hires, dispReq, dispAddr, cpuReq, cpuWe, cpuAddr, cpuWData, clearStart, ramRData,
    output dispData, dispValid, cpuRData, cpuAck, clearBusy, ramAddr, ramWe, ramWData
  );

  // requester / RAM side
  modport master (
    output hires, dispReq, dispAddr, cpuReq, cpuWe, cpuAddr, cpuWData, clearStart, ramRData,
    input  dispData, dispValid, cpuRData, cpuAck, clearBusy, ramAddr, ramWe, ramWData
  );
endinterface

// File: rtl/fb_arbiter.sv
// Shares the single-port framebuffer RAM between display scanout, the clear sequencer and the CPU.
// Latency: fixed 3 cycles from grant to dispValid/cpuAck, reads and writes alike.
// Backpressure: display always wins; clear stalls on display cycles; CPU waits until both are idle.
module fb_arbiter #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 16,
  parameter int HIRES_WORDS = 512,
  parameter int LORES_WORDS = 128
) (
  input  logic        i_clk,
  input  logic        i_reset,
  fb_arbiter_if.slave io_fb
);

  localparam logic [ADDR_W-1:0] HIRES_LIM = ADDR_W'(HIRES_WORDS - 1);
  localparam logic [ADDR_W-1:0] LORES_LIM = ADDR_W'(LORES_WORDS - 1);

  typedef enum logic [0:0] {
    CLR_IDLE     = 1'b0,
    CLR_CLEARING = 1'b1
  } clr_state_t;

  // clear sequencer state
  clr_state_t        r_clr_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] r_clr_lim;
  logic              r_clear_busy;

  // CPU transaction in flight (grant until ack)
  logic              r_cpu_pending;

  // RAM issue registers
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_we;
  logic [DATA_W-1:0] r_ram_wdata;

  // pipeline tags: s1 = RAM access cycle, s2 = RAM data valid cycle
  logic              r_s1_disp;
  logic              r_s1_cpu;
  logic              r_s1_rd;
  logic              r_s2_disp;
  logic              r_s2_cpu;
  logic              r_s2_rd;

  // retired results
  logic [DATA_W-1:0] r_disp_data;
  logic              r_disp_vld;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_cpu_ack;

  // arbitration
  logic              w_clearing;
  logic              w_gnt_disp;
  logic              w_gnt_clr;
  logic              w_gnt_cpu;

  // Fixed priority display > clear > CPU. The CPU is also held off on a clearStart
  // cycle and on its own ack cycle, so a held request costs at least 4 cycles each.
  always_comb begin
    w_clearing = (r_clr_state == CLR_CLEARING);
    w_gnt_disp = io_fb.dispReq;
    w_gnt_clr  = !io_fb.dispReq && w_clearing;
    w_gnt_cpu  = io_fb.cpuReq && !r_cpu_pending && !w_clearing && !io_fb.clearStart &&
                 !io_fb.dispReq && !r_cpu_ack;
  end

  // Clear FSM: latch the word limit at start, advance only on cycles it owns the RAM.
  // A restart still lets the current cycle's write go out before the counter rewinds.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_clr_state  <= CLR_IDLE;
      r_clr_cnt    <= '0;
      r_clr_lim    <= '0;
      r_clear_busy <= 1'b0;
    end else if (io_fb.clearStart) begin
      r_clr_state  <= CLR_CLEARING;
      r_clr_cnt    <= '0;
      r_clr_lim    <= io_fb.hires ? HIRES_LIM : LORES_LIM;
      r_clear_busy <= 1'b1;
    end else if (w_gnt_clr) begin
      if (r_clr_cnt == r_clr_lim) begin
        r_clr_state  <= CLR_IDLE;
        r_clear_busy <= 1'b0;
      end else begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  // CPU pending flag: set on grant, released as the ack is registered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cpu_pending <= 1'b0;
    end else if (w_gnt_cpu) begin
      r_cpu_pending <= 1'b1;
    end else if (r_s2_cpu) begin
      r_cpu_pending <= 1'b0;
    end
  end

  // Register the winning access onto the RAM port and tag it for the return path.
  // The address holds when idle; only the write enable is forced low.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_s1_disp   <= 1'b0;
      r_s1_cpu    <= 1'b0;
      r_s1_rd     <= 1'b0;
    end else begin
      r_ram_we  <= w_gnt_clr || (w_gnt_cpu && io_fb.cpuWe);
      r_s1_disp <= w_gnt_disp;
      r_s1_cpu  <= w_gnt_cpu;
      r_s1_rd   <= w_gnt_cpu && !io_fb.cpuWe;
      if (w_gnt_disp) begin
        r_ram_addr  <= io_fb.dispAddr;
        r_ram_wdata <= '0;
      end else if (w_gnt_clr) begin
        r_ram_addr  <= r_clr_cnt;
        r_ram_wdata <= '0;
      end else if (w_gnt_cpu) begin
        r_ram_addr  <= io_fb.cpuAddr;
        r_ram_wdata <= io_fb.cpuWe ? io_fb.cpuWData : '0;
      end
    end
  end

  // Delay the tags across the RAM's one-cycle read latency.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s2_disp <= 1'b0;
      r_s2_cpu  <= 1'b0;
      r_s2_rd   <= 1'b0;
    end else begin
      r_s2_disp <= r_s1_disp;
      r_s2_cpu  <= r_s1_cpu;
      r_s2_rd   <= r_s1_rd;
    end
  end

  // Retire: capture read data into the owner's register; each holds until its next read.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_disp_data <= '0;
      r_disp_vld  <= 1'b0;
      r_cpu_rdata <= '0;
      r_cpu_ack   <= 1'b0;
    end else begin
      r_disp_vld <= r_s2_disp;
      r_cpu_ack  <= r_s2_cpu;
      if (r_s2_disp) begin
        r_disp_data <= io_fb.ramRData;
      end
      if (r_s2_cpu && r_s2_rd) begin
        r_cpu_rdata <= io_fb.ramRData;
      end
    end
  end

  assign io_fb.dispData  = r_disp_data;
  assign io_fb.dispValid = r_disp_vld;
  assign io_fb.cpuRData  = r_cpu_rdata;
  assign io_fb.cpuAck    = r_cpu_ack;
  assign io_fb.clearBusy = r_clear_busy;
  assign io_fb.ramAddr   = r_ram_addr;
  assign io_fb.ramWe     = r_ram_we;
  assign io_fb.ramWData  = r_ram_wdata;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: behavioural RAM, table of CPU transactions, scoreboard queues for
// display and CPU results checked on dispValid/cpuAck, plus clear and reset sequences.
module tb_fb_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic preload = 1'b1;

  always #5 clk = ~clk;

  fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) fb();

  fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HIRES_WORDS(512), .LORES_WORDS(128)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .io_fb  (fb)
  );

  // behavioural framebuffer RAM, 1-cycle synchronous read
  logic [15:0] ram [0:511];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) ram[i] <= 16'hAAAA;
    end else if (fb.ramWe) begin
      ram[fb.ramAddr] <= fb.ramWData;
    end
    fb.ramRData <= ram[fb.ramAddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } vec_t;

  exp_t dq[$];
  exp_t cq[$];
  exp_t em;
  exp_t ed;

  int n_total = 0;
  int n_pass  = 0;
  int zcount  = 0;

  logic [15:0] mdl [0:511];
  vec_t        tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // scoreboard pop on every retire; zero writes counted as clear traffic
  always @(negedge clk) begin
    if (fb.ramWe === 1'b1 && fb.ramWData === 16'h0000) zcount++;
    if (fb.dispValid === 1'b1) begin
      if (dq.size() == 0) chk("disp_unexpected", 1, 0);
      else begin
        em = dq.pop_front();
        chk("disp_cycle", cyc, em.cyc);
        chk("disp_data", fb.dispData, em.data);
      end
    end
    if (fb.cpuAck === 1'b1) begin
      if (cq.size() == 0) chk("cpu_unexpected", 1, 0);
      else begin
        em = cq.pop_front();
        chk("cpu_cycle", cyc, em.cyc);
        chk("cpu_rdata", fb.cpuRData, em.data);
      end
    end
  end

  // single CPU transaction on an idle bus; returns one cycle after the ack
  task automatic cpu_op(input logic we, input logic [8:0] addr, input logic [15:0] wdata,
                        input logic [15:0] rdata);
    logic ok;
    int   ec;
    exp_t e2;
    fb.cpuReq = 1'b1; fb.cpuWe = we; fb.cpuAddr = addr; fb.cpuWData = wdata;
    ec = cyc + 3;
    e2.cyc = ec; e2.data = rdata;
    cq.push_back(e2);
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (cyc == ec - 2) begin
        chk("op_ram_we", fb.ramWe, we);
        chk("op_ram_addr", fb.ramAddr, addr);
      end
      if (fb.cpuAck) ok = 1'b1;
    end
    fb.cpuReq = 1'b0;
    if (!ok) chk("op_ack_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int   c, exp_c, nb, jj, left, lowerr, nack, nz, zbase;
  logic got;

  initial begin
    fb.hires = 1'b0; fb.dispReq = 1'b0; fb.dispAddr = '0; fb.cpuReq = 1'b0; fb.cpuWe = 1'b0;
    fb.cpuAddr = '0; fb.cpuWData = '0; fb.clearStart = 1'b0;
    for (int i = 0; i < 512; i++) mdl[i] = 16'hAAAA;

    tbl[0] = '{1'b1, 9'd5,   16'h00FF, 16'h0000};
    tbl[1] = '{1'b0, 9'd5,   16'h0000, 16'h00FF};
    tbl[2] = '{1'b1, 9'h1FF, 16'h1234, 16'h00FF};
    tbl[3] = '{1'b0, 9'h1FF, 16'h0000, 16'h1234};
    tbl[4] = '{1'b1, 9'd0,   16'hBEEF, 16'h1234};
    tbl[5] = '{1'b1, 9'd0,   16'hCAFE, 16'h1234};
    tbl[6] = '{1'b0, 9'd0,   16'h0000, 16'hCAFE};
    tbl[7] = '{1'b0, 9'd5,   16'h0000, 16'h00FF};
    tbl[8] = '{1'b0, 9'd6,   16'h0000, 16'hAAAA};

    // reset state
    repeat (3) @(negedge clk);
    reset = 1'b0; preload = 1'b0;
    chk("rst_dispValid", fb.dispValid, 0);
    chk("rst_cpuAck", fb.cpuAck, 0);
    chk("rst_clearBusy", fb.clearBusy, 0);
    chk("rst_ramWe", fb.ramWe, 0);
    chk("rst_ramAddr", fb.ramAddr, 0);
    chk("rst_ramWData", fb.ramWData, 0);
    chk("rst_dispData", fb.dispData, 0);
    chk("rst_cpuRData", fb.cpuRData, 0);
    @(negedge clk);

    // CPU table with cpuReq held across records: one transaction per 4 cycles
    for (int i = 0; i < 9; i++) begin
      fb.cpuReq = 1'b1; fb.cpuWe = tbl[i].we; fb.cpuAddr = tbl[i].addr; fb.cpuWData = tbl[i].wdata;
      exp_c = (i == 0) ? cyc + 3 : cyc + 4;
      ed.cyc = exp_c; ed.data = tbl[i].rdata;
      cq.push_back(ed);
      if (tbl[i].we) mdl[tbl[i].addr] = tbl[i].wdata;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        if (cyc == exp_c - 2) begin
          chk("tbl_ram_we", fb.ramWe, tbl[i].we);
          chk("tbl_ram_addr", fb.ramAddr, tbl[i].addr);
          if (tbl[i].we) chk("tbl_ram_wdata", fb.ramWData, tbl[i].wdata);
        end
        if (fb.cpuAck) got = 1'b1;
      end
      if (!got) chk("tbl_ack_timeout", 0, 1);
    end
    fb.cpuReq = 1'b0;
    repeat (2) @(negedge clk);

    // 20 back-to-back display reads with a CPU read held pending
    c = cyc;
    fb.cpuReq = 1'b1; fb.cpuWe = 1'b0; fb.cpuAddr = 9'h1FF;
    ed.cyc = c + 23; ed.data = mdl[9'h1FF];
    cq.push_back(ed);
    for (int j = 0; j < 20; j++) begin
      fb.dispReq = 1'b1; fb.dispAddr = 9'(j);
      ed.cyc = cyc + 3; ed.data = mdl[j];
      dq.push_back(ed);
      @(negedge clk);
    end
    fb.dispReq = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (fb.cpuAck) got = 1'b1;
    end
    if (!got) chk("disp_cpu_ack_timeout", 0, 1);
    fb.cpuReq = 1'b0;
    repeat (2) @(negedge clk);
    chk("disp_q_empty", dq.size(), 0);
    chk("disp_hold", fb.dispData, mdl[19]);

    // lores clear, no other traffic
    zbase = zcount;
    fb.hires = 1'b0; fb.clearStart = 1'b1;
    @(negedge clk);
    fb.clearStart = 1'b0;
    nb = 0;
    while (fb.clearBusy && nb < 2000) begin nb++; @(negedge clk); end
    chk("lores_busy_cycles", nb, 128);
    repeat (2) @(negedge clk);
    chk("lores_zero_writes", zcount - zbase, 128);
    nz = 0;
    for (int i = 0; i < 128; i++) if (ram[i] !== 16'h0000) nz++;
    chk("lores_nonzero", nz, 0);
    chk("lores_addr128", ram[128], 16'hAAAA);
    for (int i = 0; i < 128; i++) mdl[i] = 16'h0000;
    cpu_op(1'b0, 9'd128, 16'h0000, 16'hAAAA);
    cpu_op(1'b0, 9'd127, 16'h0000, 16'h0000);

    // hires clear, display every 4th cycle, CPU read pending throughout
    zbase = zcount;
    fb.hires = 1'b1; fb.clearStart = 1'b1;
    fb.cpuReq = 1'b1; fb.cpuWe = 1'b0; fb.cpuAddr = 9'd300;
    left = 512; lowerr = 0; jj = 1;
    while (jj < 1200) begin
      @(negedge clk);
      fb.clearStart = 1'b0;
      if (jj == 100) fb.hires = 1'b0;
      if (left == 0) begin
        chk("hires_busy_drop", fb.clearBusy, 0);
        fb.dispReq = 1'b0;
        ed.cyc = cyc + 3; ed.data = 16'h0000;
        cq.push_back(ed);
        break;
      end
      if (!fb.clearBusy) lowerr++;
      if (jj % 4 == 0) begin
        fb.dispReq = 1'b1; fb.dispAddr = 9'(jj % 128);
        ed.cyc = cyc + 3; ed.data = 16'h0000;
        dq.push_back(ed);
      end else begin
        fb.dispReq = 1'b0;
        left--;
      end
      jj++;
    end
    chk("hires_loop_done", left, 0);
    chk("hires_busy_gap", lowerr, 0);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (fb.cpuAck) got = 1'b1;
    end
    if (!got) chk("hires_cpu_ack_timeout", 0, 1);
    fb.cpuReq = 1'b0;
    repeat (2) @(negedge clk);
    chk("hires_zero_writes", zcount - zbase, 512);
    nz = 0;
    for (int i = 0; i < 512; i++) if (ram[i] !== 16'h0000) nz++;
    chk("hires_nonzero", nz, 0);
    chk("hires_q_empty", dq.size() + cq.size(), 0);

    // hires clear restarted once the counter reaches 300
    zbase = zcount;
    fb.hires = 1'b1; fb.clearStart = 1'b1;
    nb = 0;
    for (int j = 1; j < 2000; j++) begin
      @(negedge clk);
      fb.clearStart = (j == 301);
      if (fb.clearBusy) nb++;
      else break;
    end
    chk("restart_busy_cycles", nb, 813);
    repeat (2) @(negedge clk);
    chk("restart_zero_writes", zcount - zbase, 813);

    // reset one cycle after a CPU grant
    cpu_write_then_reset: begin
      fb.cpuReq = 1'b1; fb.cpuWe = 1'b1; fb.cpuAddr = 9'd10; fb.cpuWData = 16'h5555;
      @(negedge clk);
      fb.cpuReq = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rstcpu_ramWe", fb.ramWe, 0);
      chk("rstcpu_busy", fb.clearBusy, 0);
      nack = 0;
      repeat (6) begin @(negedge clk); if (fb.cpuAck) nack++; end
      chk("rstcpu_no_ack", nack, 0);
    end

    // reset one cycle into a clear
    zbase = zcount;
    fb.clearStart = 1'b1;
    @(negedge clk);
    fb.clearStart = 1'b0;
    chk("rstclr_busy_before", fb.clearBusy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstclr_busy", fb.clearBusy, 0);
    chk("rstclr_ramWe", fb.ramWe, 0);
    repeat (3) @(negedge clk);
    chk("rstclr_busy_later", fb.clearBusy, 0);
    chk("rstclr_no_writes", zcount - zbase, 0);

    // normal traffic after reset
    cpu_op(1'b1, 9'd10, 16'h1357, 16'h0000);
    cpu_op(1'b0, 9'd10, 16'h0000, 16'h1357);
    repeat (2) @(negedge clk);
    chk("final_q_empty", dq.size() + cq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
Owns the single-port framebuffer RAM (512 x 16-bit words) and shares it between three requesters: display scanout reads, CPU sprite read/modify/write traffic, and a built-in clear sequencer for CLS. The display has fixed top priority so scanout never stalls. The clear engine zeroes the active playfield, and the CPU gets the remaining RAM cycles. Sits between the display/CPU blocks and the framebuffer RAM instance.

Parameters:
ADDR_W, 9, framebuffer word address width
DATA_W, 16, framebuffer word width
HIRES_WORDS, 512, words cleared in hires mode (128x64 / 16)
LORES_WORDS, 128, words cleared in lores mode (64x32 / 16)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
hires  in  1  current resolution mode; sampled only at clearStart
dispReq  in  1  one-cycle display read strobe
dispAddr  in  ADDR_W  display read address, valid with dispReq
dispData  out  DATA_W  display read data
dispValid  out  1  one-cycle pulse: dispData updated
cpuReq  in  1  CPU request level, held until cpuAck
cpuWe  in  1  1 = write, 0 = read; valid while cpuReq is high
cpuAddr  in  ADDR_W  CPU word address
cpuWData  in  DATA_W  CPU write data
cpuRData  out  DATA_W  CPU read data, valid with cpuAck on reads
cpuAck  out  1  one-cycle pulse: CPU transaction retired
clearStart  in  1  one-cycle pulse: start framebuffer clear
clearBusy  out  1  high while clear writes remain
ramAddr  out  ADDR_W  registered RAM address
ramWe  out  1  registered RAM write enable
ramWData  out  DATA_W  registered RAM write data
ramRData  in  DATA_W  RAM read data, 1-cycle synchronous read latency

Behaviour:
- Reset: all outputs 0; cpuPending, clear state and the pipeline valid bits cleared. An in-flight transaction is dropped and never acked. A clear in progress is aborted.
- Pipeline:
  - Cycle N: combinational arbitration.
  - Edge ending N: ram* registered.
  - N+2: ramRData valid; result registered at end of N+2.
  - N+3: dispValid or cpuAck pulses.
  - Fixed latency 3 cycles from grant, for reads and writes alike.
- Priority each cycle: dispReq > clear > CPU. At most one RAM access per cycle.
- Display: always granted in the cycle dispReq is high. dispValid fires exactly 3 cycles later. dispData holds until the next display read returns. Back-to-back dispReq every cycle is legal: throughput 1 per cycle.
- Clear sequencer (states IDLE, CLEARING):
  - clearStart: latch limit = hires ? HIRES_WORDS-1 : LORES_WORDS-1, counter = 0, go to CLEARING, clearBusy = 1 from the next cycle.
  - In CLEARING, each cycle without dispReq issues a write of 0 to counter, then counter increments.
  - A cycle with dispReq stalls the counter.
  - After the write at counter == limit, go to IDLE; clearBusy drops the following cycle.
  - clearStart while CLEARING restarts at 0 with a freshly sampled limit.
  - clearStart with dispReq in the same cycle: display is served; the first clear write occurs next free cycle.
  - A hires change mid-clear has no effect.
- CPU:
  - Granted only when cpuReq=1, cpuPending=0, clear IDLE (and no clearStart in the same cycle), no dispReq, and not the cpuAck cycle.
  - Grant sets cpuPending and captures cpuWe/cpuAddr/cpuWData.
  - cpuAck clears cpuPending. cpuReq seen in the ack cycle is ignored.
  - A requester holding cpuReq continuously gets one transaction per 4 cycles minimum.
  - Writes update RAM at the N+1 access. A read at or after a write's N+1 returns the new data.
- cpuRData updates only on read retires; it holds otherwise. Display and CPU results never overwrite each other.
- Addresses are ADDR_W bits with no bounds checking. The clear counter never exceeds the latched limit.

Test Plan:
- Reset, then CPU write 0x00FF to addr 5 with no other traffic → ramWe=1, ramAddr=5 one cycle after grant; cpuAck 3 cycles after grant; a subsequent CPU read of addr 5 returns cpuRData=0x00FF with cpuAck.
- dispReq every cycle for 20 cycles while cpuReq is held high → dispValid on each of cycles 3..22; no CPU grant until the first cycle without dispReq; cpuAck 3 cycles after that grant.
- hires=0, clearStart with no display traffic → exactly 128 zero writes to addrs 0..127, one per cycle; clearBusy high for 128 cycles; addr 128 untouched (preloaded 0xAAAA reads back 0xAAAA).
- hires=1 clear with dispReq on every 4th cycle → 512 zero writes total, the counter stalls on each dispReq cycle, display reads all retire at latency 3, and a CPU request pending throughout is granted only after clearBusy drops.
- clearStart reissued at counter=300 in hires → counter restarts at 0; total zero writes = 301 + 512; clearBusy stays high continuously.
- Assert reset 1 cycle after a CPU grant and 1 cycle into a clear → no cpuAck, clearBusy=0 and ramWe=0 the cycle after reset; a new request after reset completes normally.
